ads127l01_fsync_master_model: RTL and testbench

Behavioral-synthesizable model of a TI ADS127L01 ADC running in frame-sync master mode at a nominal 512 kSPS. It generates SCK, FSYNC and DOUT from the system clock and serializes a 24-bit two's-complement sample, supplied on a parallel input, once per frame. It sits in simulation benches and loopback builds in front of the ADC receiver/SPI-capture logic, standing in for the real converter.

---
 rtl/ads127l01_pkg.sv | 7 +
 rtl/ads127l01_sck_gen.sv | 46 ++++
 rtl/ads127l01_fsync_master_model.sv | 117 +++++++++++
 tb/tb_ads127l01_fsync_master_model.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ads127l01_pkg.sv
// Shared widths and sample type for the ADS127L01 frame-sync master model.
package ads127l01_pkg;
  localparam int DATA_W   = 24;
  localparam int STATUS_W = 8;

  typedef logic signed [DATA_W-1:0] sample_t;
endpackage

// File: rtl/ads127l01_sck_gen.sv
// SCK phase counter: registered SCK level plus falling/rising-edge strobes.
// While adv is low the phase is held at 0, so SCK idles low.
module ads127l01_sck_gen
  import ads127l01_pkg::*;
#(
  parameter int SCK_HALF = 2,
  parameter int PH_W     = $clog2(2 * SCK_HALF)
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic            adv,
  output logic [PH_W-1:0] ph,
  output logic            sck,
  output logic            sck_fall,
  output logic            sck_rise
);
  localparam logic [PH_W-1:0] PH_MAX  = PH_W'(2 * SCK_HALF - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(SCK_HALF);

  logic [PH_W-1:0] ph_q, ph_d;
  logic            sck_q, sck_d;

  always_comb begin
    ph_d = '0;
    if (adv && ph_q != PH_MAX) begin
      ph_d = ph_q + 1'b1;
    end
    sck_d    = (ph_d >= PH_HALF);
    // Strobes mark the aclk edge on which SCK changes level.
    sck_fall = adv && (ph_q == PH_MAX);
    sck_rise = adv && (ph_q == PH_HALF - 1'b1);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ph_q  <= '0;
      sck_q <= 1'b0;
    end else begin
      ph_q  <= ph_d;
      sck_q <= sck_d;
    end
  end

  assign ph  = ph_q;
  assign sck = sck_q;
endmodule

// File: rtl/ads127l01_fsync_master_model.sv
// ADS127L01 frame-sync master model: serializes din MSB first once per frame.
// Define ADS127L01_MODEL_STATUS_EN to send an 8-bit frame counter in SCK periods 24..31.
module ads127l01_fsync_master_model
  import ads127l01_pkg::*;
#(
  parameter int SCK_HALF  = 2,
  parameter int FRAME_SCK = 48
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic              sck,
  output logic              dout,
  output logic              fsync
);
  localparam int PH_W = $clog2(2 * SCK_HALF);
  localparam int K_W  = $clog2(FRAME_SCK);
  localparam logic [K_W-1:0] K_MAX = K_W'(FRAME_SCK - 1);

  logic [PH_W-1:0] ph;
  logic            sck_fall, sck_rise;
  logic            unused_gen;

  logic            run_q, run_d;
  logic [K_W-1:0]  k_q, k_d;
  sample_t         shreg_q, shreg_d;
  logic            dout_q, dout_d;
  logic            fsync_q, fsync_d;
  logic [4:0]      bit_idx;
`ifdef ADS127L01_MODEL_STATUS_EN
  logic [STATUS_W-1:0] status_q, status_d;
`endif

  ads127l01_sck_gen #(
    .SCK_HALF (SCK_HALF),
    .PH_W     (PH_W)
  ) u_sck_gen (
    .aclk     (aclk),
    .areset   (areset),
    .adv      (en && run_q),
    .ph       (ph),
    .sck      (sck),
    .sck_fall (sck_fall),
    .sck_rise (sck_rise)
  );

  assign unused_gen = ^{ph, sck_rise};

  always_comb begin
    run_d   = run_q;
    k_d     = k_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    fsync_d = fsync_q;
    bit_idx = '0;
`ifdef ADS127L01_MODEL_STATUS_EN
    status_d = status_q;
`endif
    if (!en) begin
      run_d   = 1'b0;
      k_d     = '0;
      dout_d  = 1'b0;
      fsync_d = 1'b0;
    end else if (!run_q || (sck_fall && k_q == K_MAX)) begin
      run_d   = 1'b1;
      k_d     = '0;
      shreg_d = din;
      dout_d  = din[DATA_W-1];
      fsync_d = 1'b1;
`ifdef ADS127L01_MODEL_STATUS_EN
      // Only a frame that ran to its last SCK period counts as completed.
      if (run_q) begin
        status_d = status_q + 1'b1;
      end
`endif
    end else if (sck_fall) begin
      k_d     = k_q + 1'b1;
      fsync_d = 1'b0;
      bit_idx = 5'(DATA_W - 1) - k_d[4:0];
      dout_d  = 1'b0;
      if (32'(k_d) < DATA_W) begin
        dout_d = shreg_q[bit_idx];
      end
`ifdef ADS127L01_MODEL_STATUS_EN
      else if (32'(k_d) < DATA_W + STATUS_W) begin
        dout_d = status_q[3'(STATUS_W - 1) - k_d[2:0]];
      end
`endif
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      run_q   <= 1'b0;
      k_q     <= '0;
      shreg_q <= '0;
      dout_q  <= 1'b0;
      fsync_q <= 1'b0;
`ifdef ADS127L01_MODEL_STATUS_EN
      status_q <= '0;
`endif
    end else begin
      run_q   <= run_d;
      k_q     <= k_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      fsync_q <= fsync_d;
`ifdef ADS127L01_MODEL_STATUS_EN
      status_q <= status_d;
`endif
    end
  end

  assign dout  = dout_q;
  assign fsync = fsync_q;
endmodule

// File: tb/tb_ads127l01_fsync_master_model.sv
// Bench for ads127l01_fsync_master_model: default and (SCK_HALF=1, FRAME_SCK=32) instances
// share stimulus; a frame-position model is compared every cycle, plus literal checks.
module tb_ads127l01_fsync_master_model;
  logic        aclk   = 1'b0;
  logic        areset = 1'b1;
  logic        en     = 1'b0;
  logic [23:0] din    = '0;
  logic [1:0]  sck_w, dout_w, fsync_w;

  int checks   = 0;
  int failures = 0;
  bit cmp_on   = 1'b0;
  int printed  = 0;

  ads127l01_fsync_master_model u_dut0 (
    .aclk(aclk), .areset(areset), .en(en), .din(din),
    .sck(sck_w[0]), .dout(dout_w[0]), .fsync(fsync_w[0])
  );

  ads127l01_fsync_master_model #(.SCK_HALF(1), .FRAME_SCK(32)) u_dut1 (
    .aclk(aclk), .areset(areset), .en(en), .din(din),
    .sck(sck_w[1]), .dout(dout_w[1]), .fsync(fsync_w[1])
  );

  always #5 aclk = ~aclk;

  function automatic int half_of(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int period_of(int i);
    return (i == 0) ? 192 : 64;
  endfunction

  // Model: position t (aclk cycles since frame start) fully determines the outputs.
  bit          m_run   [2] = '{1'b0, 1'b0};
  int          m_t     [2] = '{0, 0};
  logic [23:0] m_latch [2] = '{24'h0, 24'h0};
  logic [7:0]  m_cnt   [2] = '{8'h0, 8'h0};
  int          cyc = 0;

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < 2; i++) begin
        m_run[i] <= 1'b0;
        m_t[i]   <= 0;
        m_cnt[i] <= 8'h0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (!en) begin
          m_run[i] <= 1'b0;
          m_t[i]   <= 0;
        end else if (!m_run[i] || m_t[i] == period_of(i) - 1) begin
          if (m_run[i]) m_cnt[i] <= m_cnt[i] + 8'd1;
          m_run[i]   <= 1'b1;
          m_t[i]     <= 0;
          m_latch[i] <= din;
        end else begin
          m_t[i] <= m_t[i] + 1;
        end
      end
    end
  end

  // Returns {sck, fsync, dout}.
  function automatic logic [2:0] exp_out(bit run, int t, int h, logic [23:0] latch, logic [7:0] cnt);
    int   k, p;
    logic s, f, d;
    if (!run) return 3'b000;
    k = t / (2 * h);
    p = t % (2 * h);
    s = (p >= h);
    f = (k == 0);
    d = 1'b0;
    if (k < 24) d = latch[5'(23 - k)];
`ifdef ADS127L01_MODEL_STATUS_EN
    else if (k < 32) d = cnt[3'(31 - k)];
`else
    else d = cnt[0] & 1'b0;
`endif
    return {s, f, d};
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Capture state: reassembled words, fsync period and high time per instance.
  int          bitcnt   [2] = '{99, 99};
  logic [23:0] word     [2] = '{24'h0, 24'h0};
  logic [23:0] last_word[2] = '{24'h0, 24'h0};
  int          last_rise[2] = '{-1, -1};
  int          period   [2] = '{0, 0};
  int          high_t   [2] = '{0, 0};
  logic        pf       [2] = '{1'b0, 1'b0};
  logic        ps       [2] = '{1'b0, 1'b0};

  always @(negedge aclk) begin
    logic [2:0]  e, g;
    logic [23:0] w;
    for (int i = 0; i < 2; i++) begin
      if (cmp_on) begin
        e = exp_out(m_run[i], m_t[i], half_of(i), m_latch[i], m_cnt[i]);
        g = {sck_w[i], fsync_w[i], dout_w[i]};
        checks++;
        if (g !== e) begin
          failures++;
          if (printed < 40) begin
            printed++;
            $display("FAIL model_cmp inst=%0d cyc=%0d got=%b want=%b", i, cyc, g, e);
          end
        end
      end
      if (areset) begin
        bitcnt[i]    <= 99;
        last_rise[i] <= -1;
        pf[i]        <= 1'b0;
        ps[i]        <= 1'b0;
      end else begin
        pf[i] <= fsync_w[i];
        ps[i] <= sck_w[i];
        if (fsync_w[i] && !pf[i]) begin
          if (last_rise[i] >= 0) period[i] <= cyc - last_rise[i];
          last_rise[i] <= cyc;
          bitcnt[i]    <= 0;
        end
        if (!fsync_w[i] && pf[i]) high_t[i] <= cyc - last_rise[i];
        if (sck_w[i] && !ps[i] && bitcnt[i] < 24) begin
          w = {word[i][22:0], dout_w[i]};
          word[i]   <= w;
          bitcnt[i] <= bitcnt[i] + 1;
          if (bitcnt[i] == 23) last_word[i] <= w;
        end
      end
    end
  end

  task automatic hold_and_check(logic [23:0] val, string tag);
    din = val;
    repeat (3 * 192 + 10) @(negedge aclk);
    chk({tag, "_word0"}, {8'h0, last_word[0]}, {8'h0, val});
    chk({tag, "_word1"}, {8'h0, last_word[1]}, {8'h0, val});
  endtask

  initial begin
    bit found;
    repeat (3) @(negedge aclk);
    chk("reset_outputs", {26'h0, sck_w, fsync_w, dout_w}, 32'h0);
    cmp_on = 1'b1;
    areset = 1'b0;
    en     = 1'b1;

    hold_and_check(24'hA5A5A5, "a5");
    chk("period0", period[0], 192);
    chk("high0",   high_t[0], 4);
    chk("period1", period[1], 64);
    chk("high1",   high_t[1], 2);
    hold_and_check(24'h800000, "min");
    hold_and_check(24'h7FFFFF, "max");

    for (int n = 0; n < 600; n++) begin
      din = din + 24'd1;
      @(negedge aclk);
    end

    // Drop en when instance 0 is in SCK period 10.
    found = 1'b0;
    for (int n = 0; n < 400 && !found; n++) begin
      @(negedge aclk);
      if (m_run[0] && m_t[0] == 40) found = 1'b1;
    end
    if (!found) begin
      failures++;
      $display("FAIL en_drop_wait timed out");
    end
    en = 1'b0;
    @(negedge aclk);
    chk("en_drop_idle", {29'h0, sck_w[0], fsync_w[0], dout_w[0]}, 32'h0);
    din = 24'h3C3C3C;
    repeat (5) @(negedge aclk);
    en = 1'b1;
    @(negedge aclk);
    chk("reen_fsync", {30'h0, fsync_w}, 32'h3);
    repeat (300) @(negedge aclk);
    chk("reen_word0", {8'h0, last_word[0]}, 32'h3C3C3C);

    din = 24'h5A5A5A;
    repeat (50) @(negedge aclk);
    #2 areset = 1'b1;
    #1 chk("async_reset", {26'h0, sck_w, fsync_w, dout_w}, 32'h0);
    @(negedge aclk);
    areset = 1'b0;
    repeat (3 * 192 + 10) @(negedge aclk);
    chk("post_reset_word0", {8'h0, last_word[0]}, 32'h5A5A5A);
    chk("post_reset_word1", {8'h0, last_word[1]}, 32'h5A5A5A);
    chk("post_reset_period0", period[0], 192);

`ifdef ADS127L01_MODEL_STATUS_EN
    repeat (260 * 64 + 20) @(negedge aclk);
    chk("status_wrap_cnt1", {24'h0, m_cnt[1]}, 32'((260 * 64 + 20 + 3 * 192 + 10) / 64 - 0) & 32'hFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
